grant_decoder: RTL

//  Binary-index -> one-hot decoder, the inverse of the priority coder. Buffers

---
 rtl/grant_decoder.sv | 77 +++++++
 1 files changed

// File: rtl/grant_decoder.sv
// Binary index -> one-hot grant decoder fronted by a small FIFO.
// Error-flagged indices are dropped with a one-cycle co_drop pulse.
module grant_decoder #(
  parameter int output_width = 4,
  parameter int DEPTH        = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [output_width-1:0]        di_idx,
  input  logic                           di_err,
  input  logic                           di_valid,
  output logic                           do_ready,
  output logic [(2**output_width)-1:0]   do_grant,
  output logic                           do_valid,
  input  logic                           di_ack,
  output logic                           co_drop,
  output logic [$clog2(DEPTH):0]         co_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = 2 ** output_width;

  logic [output_width-1:0] mem_q [DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic                    valid_q, ready_q, drop_q;
  logic                    push, pop, drop;
  logic [output_width-1:0] head_d;

  assign push = di_valid & ready_q & ~di_err;
  assign drop = di_valid & ready_q & di_err;
  assign pop  = di_ack & valid_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    // The new head may be the slot being written on this same edge.
    head_d   = (push && (rd_ptr_d == wr_ptr_q)) ? di_idx : mem_q[rd_ptr_d];
    grant_d  = '0;
    if (count_d != '0) grant_d[head_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= di_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      grant_q  <= grant_d;
      valid_q  <= (count_d != '0);
      ready_q  <= (count_d != CW'(DEPTH));
      drop_q   <= drop;
    end
  end

  assign do_ready = ready_q;
  assign do_grant = grant_q;
  assign do_valid = valid_q;
  assign co_drop  = drop_q;
  assign co_count = count_q;

endmodule
